// File: rtl/mult_arbiter.sv
// mult_arbiter: two-port arbiter in front of one shared, registered 18x18 signed multiplier.
// Accepts at most one operand pair per cycle and returns each 36-bit product to its issuer
// as a one-cycle pulse, together with the request tag. Responses cannot be stalled.
//
// The multiplier stage matches mult18x18_2c: an operand register followed by a product
// register, enable tied high and cleared by rst. That gives two edges of latency, so LAT
// must stay at 2 unless the multiplier stage changes.
//
// Build option MULT_ARB_FIXED_PRIO_EN: when defined, port 0 always wins contention and the
// round-robin pointer is not built. When undefined (default), arbitration is round-robin.
module mult_arbiter #(
  parameter int unsigned TAGW = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  // Port 0 request
  input  logic            req0_valid,
  input  logic [17:0]     req0_a,
  input  logic [17:0]     req0_b,
  input  logic [TAGW-1:0] req0_tag,
  output logic            req0_ready,
  // Port 1 request
  input  logic            req1_valid,
  input  logic [17:0]     req1_a,
  input  logic [17:0]     req1_b,
  input  logic [TAGW-1:0] req1_tag,
  output logic            req1_ready,
  // Shared response
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [35:0]     rsp_p,
  output logic [TAGW-1:0] rsp_tag
);

  logic grant0;
  logic grant1;

  // Multiplier stage
  logic signed [17:0] mul_a_d, mul_a_q;
  logic signed [17:0] mul_b_d, mul_b_q;
  logic signed [35:0] mul_p_d, mul_p_q;

  // In-flight tracking: one {valid, owner, tag} entry per multiplier stage
  logic [LAT-1:0]           trk_vld_d, trk_vld_q;
  logic [LAT-1:0]           trk_own_d, trk_own_q;
  logic [LAT-1:0][TAGW-1:0] trk_tag_d, trk_tag_q;

`ifdef MULT_ARB_FIXED_PRIO_EN

  // Fixed priority: port 1 only gets the multiplier when port 0 is idle
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

`else

  // Port that last transferred; 1 after reset so port 0 wins the first contention
  logic last_d, last_q;

  // Round-robin: a lone requester always wins, under contention the port != last wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = ~last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  // Pointer moves only when a transfer actually happens
  always_comb begin
    last_d = last_q;
    if (grant0) begin
      last_d = 1'b0;
    end else if (grant1) begin
      last_d = 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux into the multiplier; zeros when nothing is granted
  always_comb begin
    mul_a_d = '0;
    mul_b_d = '0;
    if (grant0) begin
      mul_a_d = req0_a;
      mul_b_d = req0_b;
    end else if (grant1) begin
      mul_a_d = req1_a;
      mul_b_d = req1_b;
    end
  end

  // Full-precision product; size casts sign-extend the signed operands before multiplying
  always_comb begin
    mul_p_d = 36'(mul_a_q) * 36'(mul_b_q);
  end

  // Multiplier operand and product registers, advancing every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      mul_p_q <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      mul_p_q <= mul_p_d;
    end
  end

  // Tracking shift register: entry 0 reloads every edge, older entries shift along
  always_comb begin
    trk_vld_d    = trk_vld_q;
    trk_own_d    = trk_own_q;
    trk_tag_d    = trk_tag_q;
    trk_vld_d[0] = grant0 | grant1;
    trk_own_d[0] = grant1;
    trk_tag_d[0] = '0;
    if (grant0) begin
      trk_tag_d[0] = req0_tag;
    end else if (grant1) begin
      trk_tag_d[0] = req1_tag;
    end
    for (int unsigned i = 1; i < LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_own_d[i] = trk_own_q[i-1];
      trk_tag_d[i] = trk_tag_q[i-1];
    end
  end

  // Tracking registers; reset drops every in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q <= '0;
      trk_own_q <= '0;
      trk_tag_q <= '0;
    end else begin
      trk_vld_q <= trk_vld_d;
      trk_own_q <= trk_own_d;
      trk_tag_q <= trk_tag_d;
    end
  end

  // Oldest tracking entry steers the product back to its owner
  always_comb begin
    rsp0_valid = trk_vld_q[LAT-1] & ~trk_own_q[LAT-1];
    rsp1_valid = trk_vld_q[LAT-1] &  trk_own_q[LAT-1];
    rsp_tag    = trk_tag_q[LAT-1];
    rsp_p      = mul_p_q;
  end

endmodule
